// File: rtl/dualmem_stream_reader.sv
// Burst read initiator for one port of a byte-write dual-port RAM.
// Issues sequential reads and re-times the 1-cycle RAM latency into a valid/ready stream.
module dualmem_stream_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_W-1:0]     base_addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic                  mem_en_o,
    output logic [DATA_W/8-1:0]   mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  tvalid_o,
    input  logic                  tready_i,
    output logic [DATA_W-1:0]     tdata_o,
    output logic                  tlast_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    issued_q, issued_d;
    logic [LEN_W-1:0]    beats_q, beats_d;
    logic                aborted_q, aborted_d;
    logic                inflight_q;
    logic [DATA_W-1:0]   buf_q [2];
    logic                rd_ptr_q, wr_ptr_q;
    logic [1:0]          count_q;

    logic                pop, push, flush, mem_en;
    logic [LEN_W-1:0]    len_clamp;
    logic [2:0]          occ;

    assign len_clamp = (len_i > MAX_LEN) ? MAX_LEN : len_i;
    assign pop       = tvalid_o & tready_i;
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q};

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        issued_d  = issued_q;
        beats_d   = beats_q;
        aborted_d = aborted_q;
        mem_en    = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d    = base_addr_i;
                    len_d     = len_clamp;
                    issued_d  = '0;
                    beats_d   = '0;
                    aborted_d = 1'b0;
                    state_d   = (len_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // pop cannot exceed count_q, so occ - pop never underflows
                mem_en = (issued_q < len_q) && !abort_i &&
                         ((occ - {2'b00, pop}) < 3'd2);
                push = inflight_q;
                if (mem_en) issued_d = issued_q + LEN_W'(1);
                if (pop)    beats_d  = beats_q + LEN_W'(1);
                if (pop && tlast_o) begin
                    state_d = DONE;
                end else if (abort_i) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                    push      = 1'b0;
                    flush     = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beats_q    <= '0;
            aborted_q  <= 1'b0;
            inflight_q <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            beats_q    <= beats_d;
            aborted_q  <= aborted_d;
            inflight_q <= mem_en;
            if (flush) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    buf_q[wr_ptr_q] <= mem_rdata_i;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    assign busy_o      = (state_q == RUN) || (state_q == DONE);
    assign done_o      = (state_q == DONE);
    assign aborted_o   = (state_q == DONE) && aborted_q;
    assign mem_en_o    = mem_en;
    assign mem_addr_o  = mem_en ? (base_q + issued_q[ADDR_W-1:0]) : '0;
    assign mem_we_o    = '0;
    assign mem_wdata_o = '0;
    assign tvalid_o    = (count_q != '0);
    assign tdata_o     = buf_q[rd_ptr_q];
    // The head entry is always beat number beats_q
    assign tlast_o     = tvalid_o && (beats_q == len_q - LEN_W'(1));

endmodule

// File: tb/tb_dualmem_stream_reader.sv
// Bench for dualmem_stream_reader: RAM model, per-cycle stream monitor with a
// beat-index reference model, table-driven bursts plus reset/abort sequences.
module tb_dualmem_stream_reader;
    localparam int AW = 9;
    localparam int DW = 64;
    localparam int LW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i, start_i, abort_i, tready_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o, aborted_o, mem_en_o, tvalid_o, tlast_o;
    logic [DW/8-1:0] mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i, tdata_o;

    dualmem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o), .mem_en_o(mem_en_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .tvalid_o(tvalid_o), .tready_i(tready_i),
        .tdata_o(tdata_o), .tlast_o(tlast_o)
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] ram [512];
    always @(posedge clk_i) if (mem_en_o) mem_rdata_i <= ram[mem_addr_o];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: beat k of a burst is ram[(base+k) mod 512], last when k==len-1
    bit   m_busy = 0, pend_done = 0, pend_ab = 0, prev_stall = 0;
    bit   was_busy, hs;
    int   m_len, m_base, issued, popped, rel, first_en_rel, done_rel;
    int   done_cnt = 0;
    bit   last_ab;
    int   beat_rel [16];
    logic [63:0] prev_d;
    logic prev_l;

    always @(negedge clk_i) begin
        was_busy = m_busy;
        hs = tvalid_o && tready_i;
        rel++;
        if (rst_i) begin
            m_busy = 0; pend_done = 0; prev_stall = 0;
            chk("rst_busy", busy_o, 0);
            chk("rst_tvalid", tvalid_o, 0);
            chk("rst_mem_en", mem_en_o, 0);
            chk("rst_done", done_o, 0);
        end else begin
            if (pend_done) begin
                chk("done_pulse", done_o, 1);
                chk("aborted_o", aborted_o, pend_ab);
                chk("done_tvalid", tvalid_o, 0);
                chk("done_mem_en", mem_en_o, 0);
                done_cnt++; last_ab = aborted_o; done_rel = rel;
                m_busy = 0; pend_done = 0;
            end else if (m_busy) begin
                chk("run_busy", busy_o, 1);
                chk("run_no_done", done_o, 0);
                chk("we_zero", {mem_we_o != 0, mem_wdata_o != 0}, 0);
                if (prev_stall) begin
                    chk("stall_valid", tvalid_o, 1);
                    chk("stall_data", tdata_o, prev_d);
                    chk("stall_last", tlast_o, prev_l);
                end
                chk("abort_no_en", abort_i && mem_en_o, 0);
                chk("occupancy", (issued + int'(mem_en_o) - popped - int'(hs)) <= 2, 1);
                if (mem_en_o) begin
                    chk("over_issue", issued < m_len, 1);
                    chk("mem_addr", mem_addr_o, (m_base + issued) % 512);
                    if (first_en_rel < 0) first_en_rel = rel;
                    issued++;
                end
                if (hs) begin
                    chk("extra_beat", popped < m_len, 1);
                    chk("tdata", tdata_o, ram[(m_base + popped) % 512]);
                    chk("tlast", tlast_o, popped == m_len - 1);
                    if (popped < 16) beat_rel[popped] = rel;
                    popped++;
                end
                if (hs && popped == m_len) begin
                    pend_done = 1; pend_ab = 0;
                end else if (abort_i) begin
                    pend_done = 1; pend_ab = 1;
                end
                prev_stall = tvalid_o && !tready_i && !abort_i;
                prev_d = tdata_o; prev_l = tlast_o;
            end else begin
                chk("idle_busy", busy_o, 0);
                chk("idle_tvalid", tvalid_o, 0);
                chk("idle_mem_en", mem_en_o, 0);
                chk("idle_done", done_o, 0);
            end
            if (start_i && !was_busy) begin
                m_len = (int'(len_i) > 512) ? 512 : int'(len_i);
                m_base = int'(base_addr_i);
                issued = 0; popped = 0; rel = 0; first_en_rel = -1; done_rel = -1;
                for (int k = 0; k < 16; k++) beat_rel[k] = -1;
                m_busy = 1; prev_stall = 0;
                pend_done = (m_len == 0); pend_ab = 0;
            end
        end
    end

    typedef struct {
        int base; int len; int mode; int abort_at; int exp_beats; bit exp_ab;
    } vec_t;
    vec_t tbl [11];

    // mode: 0 ready high, 1 random ready, 2 random with 6-cycle stall,
    //       3 ready high + start pulses during RUN, 4 ready high and kept high on abort
    task automatic run_burst(input int base, input int len, input int mode,
                             input int abort_at, input int exp_beats, input bit exp_ab);
        int  dc0;
        bit  aborted_sent = 0;
        bit  got = 0;
        @(posedge clk_i); #1;
        start_i = 1; base_addr_i = AW'(base); len_i = LW'(len); abort_i = 0;
        tready_i = (mode == 1 || mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        dc0 = done_cnt;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(posedge clk_i); #1;
            start_i = 0;
            if (done_cnt != dc0) begin got = 1; break; end
            abort_i = 0;
            case (mode)
                1:       tready_i = ($urandom_range(0, 3) != 0);
                2:       tready_i = (cyc >= 2 && cyc < 8) ? 1'b0 : 1'($urandom_range(0, 1));
                default: tready_i = 1'b1;
            endcase
            if (mode == 3 && (cyc == 2 || cyc == 4)) begin
                start_i = 1; base_addr_i = 9'h080; len_i = 10'd3;
            end
            if (abort_at >= 0 && !aborted_sent && popped == abort_at && m_busy && !pend_done) begin
                abort_i = 1; aborted_sent = 1;
                if (mode != 4) tready_i = 0;
            end
        end
        abort_i = 0; start_i = 0;
        chk("done_seen", got, 1);
        chk("beat_count", popped, exp_beats);
        chk("aborted_flag", last_ab, exp_ab);
    endtask

    bit seen_done;

    initial begin
        rst_i = 1; start_i = 0; abort_i = 0; tready_i = 0;
        base_addr_i = '0; len_i = '0;
        for (int a = 0; a < 512; a++) ram[a] = {32'(a), 32'(a)};
        tbl[0]  = '{32'h1FE,    4, 0, -1,   4, 0};
        tbl[1]  = '{32'h020,    8, 2, -1,   8, 0};
        tbl[2]  = '{32'h100,  600, 1, -1, 512, 0};
        tbl[3]  = '{32'h050,   10, 1,  3,   3, 1};
        tbl[4]  = '{32'h1F0,   32, 1, -1,  32, 0};
        tbl[5]  = '{32'h005,    1, 0, -1,   1, 0};
        tbl[6]  = '{32'h0A0,  512, 0, -1, 512, 0};
        tbl[7]  = '{32'h060,    3, 4,  2,   3, 0};
        tbl[8]  = '{32'h030,    6, 3, -1,   6, 0};
        tbl[9]  = '{32'h1FF,    2, 2, -1,   2, 0};
        tbl[10] = '{32'h000, 1023, 0, -1, 512, 0};

        #12;
        chk("reset_busy", busy_o, 0);
        chk("reset_tvalid", tvalid_o, 0);
        chk("reset_tdata", tdata_o, 0);
        chk("reset_mem_addr", mem_addr_o, 0);
        @(posedge clk_i); #3 rst_i = 0;

        run_burst(32'h010, 4, 0, -1, 4, 0);
        chk("first_en_cycle", first_en_rel, 1);
        chk("first_beat_cycle", beat_rel[0], 3);
        chk("last_beat_cycle", beat_rel[3], 6);
        chk("done_cycle", done_rel, 7);

        run_burst(32'h000, 0, 0, -1, 0, 0);
        chk("len0_done_cycle", done_rel, 1);
        chk("len0_no_en", first_en_rel < 0, 1);

        for (int i = 0; i < 11; i++)
            run_burst(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].abort_at,
                      tbl[i].exp_beats, tbl[i].exp_ab);

        // Reset in the middle of a burst
        @(posedge clk_i); #1;
        start_i = 1; base_addr_i = 9'h040; len_i = 10'd20; tready_i = 1;
        @(posedge clk_i); #1 start_i = 0;
        repeat (4) @(posedge clk_i);
        #3 rst_i = 1;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_tvalid", tvalid_o, 0);
        chk("midrst_tdata", tdata_o, 0);
        chk("midrst_tlast", tlast_o, 0);
        chk("midrst_mem_en", mem_en_o, 0);
        chk("midrst_mem_addr", mem_addr_o, 0);
        chk("midrst_done", {done_o, aborted_o}, 0);
        @(posedge clk_i); #3 rst_i = 0;
        seen_done = 0;
        repeat (4) begin @(negedge clk_i); seen_done |= done_o; end
        chk("midrst_no_done", seen_done, 0);
        run_burst(32'h044, 5, 0, -1, 5, 0);

        for (int a = 0; a < 512; a++) ram[a] = {$urandom, $urandom};
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(0, 40);
            run_burst($urandom_range(0, 511), len, $urandom_range(0, 2), -1, len, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
